// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter for 8 requesters sharing one decoded select.
// Registered 3-bit select with a matching one-hot grant, plus a MAX_HOLD ownership limit.
`default_nettype none

module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       release_grant,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     ptr, ptr_nxt;
    logic [2:0]     sel_nxt;
    logic [7:0]     grant_nxt;
    logic           busy_nxt;
    logic           timeout_nxt;
    logic [HCW-1:0] hold_cnt, hold_nxt;

    logic           found;
    logic [2:0]     pick_idx;
    logic [2:0]     idx;
    logic           limit_hit;
    logic           end_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= 3'd0;
            sel      <= 3'd0;
            grant    <= 8'h00;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr;
        idx      = ptr;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
    end

    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);
    assign end_grant = release_grant || !req[sel] || limit_hit;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        grant_nxt   = grant;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
        hold_nxt    = hold_cnt;

        case (state)
            S_IDLE: begin
                grant_nxt = 8'h00;
                busy_nxt  = 1'b0;
                if (en && found) begin
                    sel_nxt   = pick_idx;
                    grant_nxt = 8'd1 << pick_idx;
                    busy_nxt  = 1'b1;
                    hold_nxt  = HCW'(1);
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (end_grant) begin
                    grant_nxt   = 8'h00;
                    busy_nxt    = 1'b0;
                    ptr_nxt     = sel + 3'd1;
                    // Only flag a timeout when the hold limit was the sole reason.
                    timeout_nxt = limit_hit && !release_grant && req[sel];
                    state_nxt   = S_GAP;
                end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIMIT)) begin
                    hold_nxt = hold_cnt + HCW'(1);
                end
            end
            S_GAP: begin
                grant_nxt = 8'h00;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                grant_nxt = 8'h00;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
